// File: rtl/mant_lz_insert_seq_pkg.sv
// Shared FP datapath definitions: mantissa / leading-zero-count widths and
// the state encoding used by the iterative denormaliser.
package mant_lz_insert_seq_pkg;

  localparam int MANT_W = 8;
  localparam int LZC_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } lz_state_e;

endpackage

// File: rtl/mant_lz_insert_seq.sv
// Iterative mantissa denormaliser: inserts lz_in leading zeros by shifting
// right one bit per cycle, collecting every bit that falls off the LSB into a
// sticky flag. Single operation in flight, valid/ready on both sides.
// CNT_W must satisfy 2**CNT_W <= WIDTH so a full count never empties the
// mantissa beyond what the sticky bit can summarise.
module mant_lz_insert_seq
  import mant_lz_insert_seq_pkg::*;
#(
  parameter int WIDTH = MANT_W,
  parameter int CNT_W = LZC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mant_in,
  input  logic [CNT_W-1:0] lz_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mant_out,
  output logic             sticky_out,
  output logic             busy
);

  lz_state_e        r_state;
  lz_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  // Count still holds the pre-decrement value, so 1 means this is the final shift.
  assign w_last   = (r_cnt == CNT_W'(1));

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        // A zero count needs no shifting; the loaded value is already the answer.
        if (in_valid) w_state_nxt = (lz_in == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift register, down-counter and sticky accumulator; frozen in IDLE/DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_sreg   <= mant_in;
      r_cnt    <= lz_in;
      r_sticky <= 1'b0;
    end else if (r_state == ST_SHIFT) begin
      r_sreg   <= {1'b0, r_sreg[WIDTH-1:1]};
      r_sticky <= r_sticky | r_sreg[0];
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  assign mant_out   = r_sreg;
  assign sticky_out = r_sticky;

endmodule
